// File: rtl/evm_pkg.sv
// Shared widths and the FSM state type for the shared BCD converter.
package evm_pkg;

    localparam int BIN_W = 8;   // operand width
    localparam int BCD_W = 4;   // width of one BCD digit

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bundle between the requesters and the shared converter.
interface bcd_conv_arbiter_if
    import evm_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);

    logic [N_REQ-1:0]       req_valid;
    logic [BIN_W*N_REQ-1:0] req_bin;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [BCD_W-1:0]       rsp_thousands;
    logic [BCD_W-1:0]       rsp_hundreds;
    logic [BCD_W-1:0]       rsp_tens;
    logic [BCD_W-1:0]       rsp_ones;

    // Requester side.
    modport master (
        output req_valid, req_bin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id,
               rsp_thousands, rsp_hundreds, rsp_tens, rsp_ones
    );

    // Converter side.
    modport slave (
        input  req_valid, req_bin, rsp_ready,
        output req_ready, rsp_valid, rsp_id,
               rsp_thousands, rsp_hundreds, rsp_tens, rsp_ones
    );

endinterface

// File: rtl/binary_to_bcd.sv
// Combinational 8-bit binary to 4-digit BCD converter (shift-and-add-3).
module binary_to_bcd
    import evm_pkg::*;
(
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] thousands,
    output logic [BCD_W-1:0] hundreds,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    // A digit of 5 or more would exceed 9 after the next doubling.
    function automatic logic [BCD_W-1:0] adj(input logic [BCD_W-1:0] d);
        return (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;
    endfunction

    logic [BCD_W-1:0] d3, d2, d1, d0;
    logic [BIN_W-1:0] b;

    // Double-dabble: adjust every digit, then shift one operand bit in.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        d3 = '0;
        d2 = '0;
        d1 = '0;
        d0 = '0;
        b  = bin;
        for (int i = 0; i < BIN_W; i++) begin
            d3 = adj(d3);
            d2 = adj(d2);
            d1 = adj(d1);
            d0 = adj(d0);
            {d3, d2, d1, d0, b} = {d3, d2, d1, d0, b} << 1;
        end
        thousands = d3;
        hundreds  = d2;
        tens      = d1;
        ones      = d0;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from last+1 with wrap-around.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx
);

    int                      shamt;
    logic [2*N_REQ-1:0]      req2;
    logic [2*N_REQ-1:0]      win2;
    logic [N_REQ-1:0]        rot;
    logic [N_REQ-1:0]        lsb;
    logic [N_REQ-1:0]        raw;
    logic [ID_W-1:0]         acc [N_REQ+1];

    // Rotate so last+1 sits at bit 0, keep the lowest request, rotate back.
    always_comb begin
        shamt = int'(last) + 1;
        req2  = {req, req} >> shamt;
        rot   = req2[N_REQ-1:0];
        lsb   = rot & (~rot + N_REQ'(1));
        win2  = {lsb, lsb} << shamt;
        raw   = win2[2*N_REQ-1:N_REQ];
        gnt   = en ? raw : '0;
    end

    // One-hot to index encoder as an OR chain.
    assign acc[0] = '0;
    for (genvar i = 0; i < N_REQ; i++) begin : g_enc
        assign acc[i+1] = acc[i] | (raw[i] ? ID_W'(i) : '0);
    end
    assign gnt_idx = acc[N_REQ];

endmodule

// File: rtl/bcd_conv_arbiter.sv
// One binary_to_bcd converter shared round-robin among N_REQ requesters,
// with registered operand and registered result.
module bcd_conv_arbiter
    import evm_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_conv_arbiter_if.slave   bus,
    output logic                busy
);

    state_t           state;
    state_t           state_nxt;
    logic [BIN_W-1:0] operand;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  last;
    logic             arb_en;
    logic             take;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic [BIN_W-1:0] sel_bin;
    logic [BCD_W-1:0] conv_th, conv_hu, conv_te, conv_on;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (bus.req_valid),
        .last    (last),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    binary_to_bcd u_conv (
        .bin       (operand),
        .thousands (conv_th),
        .hundreds  (conv_hu),
        .tens      (conv_te),
        .ones      (conv_on)
    );

    assign bus.req_ready = gnt;
    assign take          = |gnt;
    assign sel_bin       = BIN_W'(bus.req_bin >> (int'(gnt_idx) * BIN_W));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking updates so all registers sample pre-edge values together.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bus.req_valid) state_nxt = CONV;
            CONV:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = (|bus.req_valid) ? CONV : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: grant window is IDLE, or RESP in the cycle the result is consumed.
    always_comb begin
        arb_en = rst_n && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
        busy   = (state != IDLE);
    end

    // Operand, owner and round-robin pointer captured on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand <= '0;
            owner   <= '0;
            last    <= ID_W'(N_REQ - 1);
        end else if (take) begin
            operand <= sel_bin;
            owner   <= gnt_idx;
            last    <= gnt_idx;
        end
    end

    // Result register: loads in CONV, holds until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid     <= 1'b0;
            bus.rsp_id        <= '0;
            bus.rsp_thousands <= '0;
            bus.rsp_hundreds  <= '0;
            bus.rsp_tens      <= '0;
            bus.rsp_ones      <= '0;
        end else if (state == CONV) begin
            bus.rsp_valid     <= 1'b1;
            bus.rsp_id        <= owner;
            bus.rsp_thousands <= conv_th;
            bus.rsp_hundreds  <= conv_hu;
            bus.rsp_tens      <= conv_te;
            bus.rsp_ones      <= conv_on;
        end else if ((state == RESP) && bus.rsp_ready) begin
            bus.rsp_valid     <= 1'b0;
        end
    end

endmodule
